// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative shift-add multiplier and restoring divider owning the HI/LO pair.
// Define MDU_DIV_EN to build the divider; without it div/divu complete in one cycle and leave HI/LO untouched.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [5:0]       MduOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [5:0] OP_MULT  = 6'b000101;
    localparam logic [5:0] OP_MULTU = 6'b000110;
    localparam logic [5:0] OP_MADD  = 6'b000111;
    localparam logic [5:0] OP_MSUB  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b001010;
    localparam logic [5:0] OP_MTLO  = 6'b001011;
    localparam logic [5:0] OP_DIV   = 6'b100110;
    localparam logic [5:0] OP_DIVU  = 6'b100111;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    typedef enum logic [1:0] {K_MULT, K_MADD, K_MSUB, K_DIV} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
`ifdef MDU_DIV_EN
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               divzero_q, divzero_d;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
`endif
    logic               is_mul, is_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, sprod, hilo, mres;

    // Operation decode, operand magnitudes and per-iteration datapath
    always_comb begin
        is_mul    = MduOp inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
        is_div    = MduOp inside {OP_DIV, OP_DIVU};
        is_signed = MduOp inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
        a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
        b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;
        mul_sum   = {1'b0, acc_q} + {1'b0, (a_q[0] ? b_q : '0)};
        prod      = {acc_q, a_q};
        sprod     = neg_q ? -prod : prod;
        hilo      = {hi_q, lo_q};
        mres      = (kind_q == K_MADD) ? hilo + sprod : (kind_q == K_MSUB) ? hilo - sprod : sprod;
`ifdef MDU_DIV_EN
        div_sh    = {acc_q, a_q[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, b_q};
        div_diff  = div_sh - {1'b0, b_q};
`endif
    end

    // Next-state, iteration and HI/LO write logic; Flush overrides everything while busy
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
`ifdef MDU_DIV_EN
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        divzero_d = divzero_q;
`endif
        if (state_q != IDLE && Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (MduOp == OP_MTHI) hi_d = A;
                        if (MduOp == OP_MTLO) lo_d = A;
                        if (is_mul || is_div) begin
                            a_d     = a_mag;
                            b_d     = b_mag;
                            acc_d   = '0;
                            cnt_d   = '0;
                            neg_d   = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            kind_d  = is_div ? K_DIV : (MduOp == OP_MADD) ? K_MADD : (MduOp == OP_MSUB) ? K_MSUB : K_MULT;
`ifdef MDU_DIV_EN
                            state_d = is_mul ? MUL : DIV;
                            rneg_d  = is_signed && A[WIDTH-1];
                            dz_d    = (B == '0);
`else
                            state_d = is_mul ? MUL : FIN;
`endif
                        end
`ifdef MDU_DIV_EN
                        if (is_mul || is_div || MduOp == OP_MTHI || MduOp == OP_MTLO) divzero_d = 1'b0;
`endif
                    end
                end
                MUL: begin
                    acc_d   = mul_sum[WIDTH:1];
                    a_d     = {mul_sum[0], a_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == LAST) ? FIN : MUL;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    acc_d   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                    a_d     = {a_q[WIDTH-2:0], div_ge};
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == LAST) ? FIN : DIV;
                end
`endif
                FIN: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (kind_q != K_DIV) {hi_d, lo_d} = mres;
`ifdef MDU_DIV_EN
                    else begin
                        hi_d      = rneg_q ? -acc_q : acc_q;
                        lo_d      = dz_q ? '1 : (neg_q ? -a_q : a_q);
                        divzero_d = dz_q;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            kind_q    <= K_MULT;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIV_EN
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            divzero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
`ifdef MDU_DIV_EN
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            divzero_q <= divzero_d;
`endif
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
`ifdef MDU_DIV_EN
    assign DivZero = divzero_q;
`else
    assign DivZero = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed checks of mdu_iterative at WIDTH=32 plus a WIDTH=8 instance against a reference model.
module tb_mdu_iterative;
    localparam logic [5:0] OP_MULT  = 6'b000101;
    localparam logic [5:0] OP_MULTU = 6'b000110;
    localparam logic [5:0] OP_MADD  = 6'b000111;
    localparam logic [5:0] OP_MSUB  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b001010;
    localparam logic [5:0] OP_MTLO  = 6'b001011;
    localparam logic [5:0] OP_DIV   = 6'b100110;
    localparam logic [5:0] OP_DIVU  = 6'b100111;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [5:0]  MduOp = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] HI, LO;

    logic        s8 = 1'b0;
    logic        f8 = 1'b0;
    logic [5:0]  op8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int failures = 0;
    bit done_seen;

    always #5 Clk = ~Clk;

    mdu_iterative #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Flush(Flush), .MduOp(MduOp), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
    );

    mdu_iterative #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst(Rst), .Start(s8), .Flush(f8), .MduOp(op8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .DivZero(dz8), .HI(hi8), .LO(lo8)
    );

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; MduOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge Clk);
            if (Done) done_seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", DivZero); end
        checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", HI); end
        checks++; if (LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", LO); end
        Rst = 1'b1;
    endtask

    task automatic test_mult;
        int n;
        issue(OP_MULT, 32'hFFFFFFFF, 32'h2);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL mult_busy got=%b exp=1", Busy); end
        wait_done(n);
        checks++; if (n != 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", n); end
        checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end
        @(negedge Clk);
        checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", Done, Busy); end
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h2);
        wait_done(n);
        checks++; if (HI !== 32'h1) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
        checks++; if (LO !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
    endtask

    task automatic test_madd;
        int n;
        issue(OP_MTLO, 32'd5, 32'd0);
        checks++; if (LO !== 32'd5 || Busy !== 1'b0) begin failures++; $display("FAIL mtlo got lo=%h busy=%b exp 5 0", LO, Busy); end
        issue(OP_MTHI, 32'd0, 32'd0);
        checks++; if (HI !== 32'd0 || Done !== 1'b0) begin failures++; $display("FAIL mthi got hi=%h done=%b exp 0 0", HI, Done); end
        issue(OP_MADD, 32'd3, 32'hFFFFFFFE);
        wait_done(n);
        checks++; if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFF) begin failures++; $display("FAIL madd got=%h exp=ffffffffffffffff", {HI, LO}); end
        issue(OP_MSUB, 32'd3, 32'hFFFFFFFE);
        wait_done(n);
        checks++; if ({HI, LO} !== 64'h00000000_00000005) begin failures++; $display("FAIL msub got=%h exp=0000000000000005", {HI, LO}); end
    endtask

    task automatic test_div;
        int n;
`ifdef MDU_DIV_EN
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        checks++; if (n != 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", n); end
        checks++; if (LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        checks++; if ({HI, LO} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_ovf got=%h exp=0000000080000000", {HI, LO}); end
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(n);
        checks++; if (n != 33) begin failures++; $display("FAIL divz_latency got=%0d exp=33", n); end
        checks++; if ({HI, LO} !== 64'h00000007_FFFFFFFF) begin failures++; $display("FAIL divz_hilo got=%h exp=00000007ffffffff", {HI, LO}); end
        checks++; if (DivZero !== 1'b1) begin failures++; $display("FAIL divz_flag got=%b exp=1", DivZero); end
        issue(OP_DIVU, 32'd100, 32'd7);
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL divz_clear got=%b exp=0", DivZero); end
        wait_done(n);
        checks++; if ({HI, LO} !== 64'h00000002_0000000E) begin failures++; $display("FAIL divu got=%h exp=000000020000000e", {HI, LO}); end
`else
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL nodiv_busy got=%b exp=1", Busy); end
        wait_done(n);
        checks++; if (n != 1) begin failures++; $display("FAIL nodiv_latency got=%0d exp=1", n); end
        checks++; if ({HI, LO} !== 64'h00000000_00000005) begin failures++; $display("FAIL nodiv_hilo got=%h exp=0000000000000005", {HI, LO}); end
        checks++; if (DivZero !== 1'b0) begin failures++; $display("FAIL nodiv_divzero got=%b exp=0", DivZero); end
`endif
    endtask

    task automatic test_flush;
        int n;
        issue(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        issue(OP_MULT, 32'd3, 32'd5);
        done_seen = 1'b0;
        idle_cycles(9);
        Start = 1'b1; MduOp = OP_MTHI; A = 32'hDEAD;
        idle_cycles(1);
        Start = 1'b0;
        checks++; if (HI !== 32'h1234) begin failures++; $display("FAIL busy_mthi got=%h exp=00001234", HI); end
        idle_cycles(9);
        Flush = 1'b1;
        idle_cycles(1);
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", Busy); end
        idle_cycles(25);
        checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", done_seen); end
        checks++; if ({HI, LO} !== 64'h00001234_00005678) begin failures++; $display("FAIL flush_hilo got=%h exp=0000123400005678", {HI, LO}); end
        issue(OP_MULT, 32'd7, 32'd6);
        wait_done(n);
        checks++; if (n != 33 || {HI, LO} !== 64'd42) begin failures++; $display("FAIL post_flush got n=%0d hilo=%h exp 33 42", n, {HI, LO}); end
    endtask

    task automatic test_rst_mid;
        issue(OP_MTHI, 32'hAAAA, 32'd0);
`ifdef MDU_DIV_EN
        issue(OP_DIV, 32'd1000, 32'd3);
`else
        issue(OP_MULT, 32'd1000, 32'd3);
`endif
        repeat (14) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got busy=%b done=%b exp 0 0", Busy, Done); end
        checks++; if ({HI, LO} !== 64'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h exp=0", {HI, LO}); end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(OP_MULT, 32'd3, 32'd4);
        wait_done(n);
        checks++; if (Done !== 1'b1 || LO !== 32'd12) begin failures++; $display("FAIL b2b_first got done=%b lo=%h exp 1 0000000c", Done, LO); end
        Start = 1'b1; MduOp = OP_MULT; A = 32'd5; B = 32'd6;
        @(negedge Clk);
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", Busy); end
        wait_done(n);
        checks++; if (n != 33 || {HI, LO} !== 64'd30) begin failures++; $display("FAIL b2b_second got n=%0d hilo=%h exp 33 30", n, {HI, LO}); end
    endtask

    task automatic test_w8;
        logic [7:0]  ta [4] = '{8'h80, 8'h7F, 8'hFF, 8'h80};
        logic [7:0]  tb [4] = '{8'hFF, 8'h00, 8'hFF, 8'h80};
        logic [5:0]  ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        logic [7:0]  a, b;
        logic [15:0] e;
        int sa, sb, ua, ub, p, q, r, n, lat;
        e = 16'h0;
        for (int i = 0; i < 40; i++) begin
            a = (i < 4) ? ta[i] : 8'($urandom_range(255));
            b = (i < 4) ? tb[i] : 8'($urandom_range(255));
            sa = $signed(a); sb = $signed(b); ua = a; ub = b;
            for (int k = 0; k < 4; k++) begin
                lat = 9;
                if (k == 0) begin p = sa * sb; e = p[15:0]; end
                else if (k == 1) begin p = ua * ub; e = p[15:0]; end
`ifdef MDU_DIV_EN
                else if (b == 8'h0) e = {a, 8'hFF};
                else if (k == 2) begin q = sa / sb; r = sa % sb; e = {r[7:0], q[7:0]}; end
                else begin q = ua / ub; r = ua % ub; e = {r[7:0], q[7:0]}; end
`else
                else lat = 1;
`endif
                @(negedge Clk);
                s8 = 1'b1; op8 = ops[k]; a8 = a; b8 = b;
                @(negedge Clk);
                s8 = 1'b0;
                n = 0;
                while (!done8 && n < 50) begin
                    @(negedge Clk);
                    n++;
                end
                checks++; if (n != lat) begin failures++; $display("FAIL w8_latency op=%b a=%h b=%h got=%0d exp=%0d", ops[k], a, b, n, lat); end
                checks++; if ({hi8, lo8} !== e) begin failures++; $display("FAIL w8_result op=%b a=%h b=%h got=%h exp=%h", ops[k], a, b, {hi8, lo8}, e); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_madd;
        test_div;
        test_flush;
        test_rst_mid;
        test_back_to_back;
        test_w8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
